sdram_responder: RTL

//  Synthesizable SDR SDRAM device emulator: the responder end of the sdram_cmd/ba/a/d

---
 rtl/sdram_responder.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_responder.sv
// sdram_responder: SDR SDRAM device emulator (command decode, open-row tracking, burst engine, backing RAM).
// Read data appears CL cycles after the READ edge; writes land on the edge that samples them.
// Optional SDRAM_RESP_TIMING_CHECK_EN adds ACTIVE->READ/WRITE and PRECHARGE->ACTIVE spacing checks.
module sdram_responder #(
   parameter int ROW_BITS = 2,
   parameter int COL_BITS = 9,
   parameter int CL_RESET = 3,
   parameter int TRCD     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  sdram_cmd,
   input  logic [1:0]  sdram_ba,
   input  logic [12:0] sdram_a,
   input  logic [15:0] sdram_dq_in,
   output logic [15:0] sdram_dq_out,
   output logic        sdram_dq_oe,
   output logic [3:0]  bank_open,
   output logic        err
);
   localparam int AW = 2 + ROW_BITS + COL_BITS;

   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_LMR = 4'b0000;
   localparam logic [3:0] CMD_BST = 4'b0110;

   typedef enum logic [1:0] {B_IDLE, B_READ, B_WRITE} burst_t;

   burst_t              state;
   logic [2:0]          cl_q;
   logic [2:0]          bl_q;
   logic [ROW_BITS-1:0] row_q [4];
   logic [1:0]          b_bank;
   logic [COL_BITS-1:0] b_col;
   logic [2:0]          b_left;

   logic                rd_vld;
   logic [15:0]         rd_q;
   logic                p1_vld, p2_vld;
   logic [15:0]         p1_dat, p2_dat;

   logic [15:0]         mem [0:(1<<AW)-1];

   logic is_act, is_rd, is_wr, is_pre, is_ref, is_lmr, is_bst;
   logic tgt_open, any_open, rw_go, stop, cont, lmr_legal, page, tim_err, err_any;
   logic acc_en, acc_wr;
   logic [1:0]          acc_bank;
   logic [COL_BITS-1:0] acc_col;
   logic [AW-1:0]       acc_addr;
   logic [2:0]          bl_left;
   logic                unused_a;

   assign is_act = (sdram_cmd == CMD_ACT);
   assign is_rd  = (sdram_cmd == CMD_RD);
   assign is_wr  = (sdram_cmd == CMD_WR);
   assign is_pre = (sdram_cmd == CMD_PRE);
   assign is_ref = (sdram_cmd == CMD_REF);
   assign is_lmr = (sdram_cmd == CMD_LMR);
   assign is_bst = (sdram_cmd == CMD_BST);

   assign unused_a = ^{sdram_a[12:11], sdram_a[9]};

   assign tgt_open  = bank_open[sdram_ba];
   assign any_open  = |bank_open;
   assign page      = (bl_q == 3'b111);
   assign rw_go     = (is_rd | is_wr) & tgt_open;
   assign stop      = is_bst | (is_pre & (sdram_a[10] | (sdram_ba == b_bank)));
   assign cont      = (state != B_IDLE) & ~stop & ~rw_go;
   assign lmr_legal = ((sdram_a[6:4] == 3'd2) | (sdram_a[6:4] == 3'd3)) &
                      (~sdram_a[2] | (sdram_a[2:0] == 3'b111));

   // Each edge performs at most one RAM access: a fresh READ/WRITE wins over the running burst
   assign acc_en   = rw_go | cont;
   assign acc_wr   = rw_go ? is_wr : (state == B_WRITE);
   assign acc_bank = rw_go ? sdram_ba : b_bank;
   assign acc_col  = rw_go ? sdram_a[COL_BITS-1:0] : b_col;
   assign acc_addr = {acc_bank, row_q[acc_bank], acc_col};

   assign err_any = (is_lmr & (any_open | ~lmr_legal)) |
                    (is_act & tgt_open) |
                    ((is_rd | is_wr) & ~tgt_open) |
                    (is_ref & any_open) |
                    tim_err;

   // Words remaining after the first one of a fixed-length burst
   always_comb begin
      bl_left = 3'd0;
      case (bl_q)
         3'b001:  bl_left = 3'd1;
         3'b010:  bl_left = 3'd3;
         3'b011:  bl_left = 3'd7;
         default: bl_left = 3'd0;
      endcase
   end

   // Next burst column: short bursts wrap inside their aligned block, full page wraps at the page end
   function automatic logic [COL_BITS-1:0] col_next(input logic [COL_BITS-1:0] c, input logic [2:0] bl);
      logic [COL_BITS-1:0] n;
      n = c + COL_BITS'(1);
      case (bl)
         3'b001:  n = {c[COL_BITS-1:1], n[0]};
         3'b010:  n = {c[COL_BITS-1:2], n[1:0]};
         3'b011:  n = {c[COL_BITS-1:3], n[2:0]};
         default: ;
      endcase
      return n;
   endfunction

`ifdef SDRAM_RESP_TIMING_CHECK_EN
   localparam logic [2:0] TRCD_C = 3'(TRCD);
   logic [2:0] act_cnt [4];
   logic [2:0] pre_cnt [4];

   // Per-bank saturating cycle counters since the last ACTIVE and the last PRECHARGE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int b = 0; b < 4; b++) begin
            act_cnt[b] <= 3'd7;
            pre_cnt[b] <= 3'd7;
         end
      end else begin
         for (int b = 0; b < 4; b++) begin
            if (is_act && !bank_open[b] && sdram_ba == 2'(b))
               act_cnt[b] <= 3'd1;
            else if (act_cnt[b] != 3'd7)
               act_cnt[b] <= act_cnt[b] + 3'd1;
            if (is_pre && (sdram_a[10] || sdram_ba == 2'(b)))
               pre_cnt[b] <= 3'd1;
            else if (pre_cnt[b] != 3'd7)
               pre_cnt[b] <= pre_cnt[b] + 3'd1;
         end
      end
   end

   assign tim_err = ((is_rd | is_wr) & (act_cnt[sdram_ba] < TRCD_C)) |
                    (is_act & (pre_cnt[sdram_ba] < 3'd2));
`else
   logic unused_trcd;
   assign unused_trcd = (TRCD > 0);
   assign tim_err     = 1'b0;
`endif

   // Command execution: mode register, open rows, burst sequencer and the err pulse
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= B_IDLE;
         cl_q      <= 3'(CL_RESET);
         bl_q      <= 3'b111;
         bank_open <= '0;
         err       <= 1'b0;
         b_bank    <= '0;
         b_col     <= '0;
         b_left    <= '0;
         for (int i = 0; i < 4; i++) row_q[i] <= '0;
      end else begin
         err <= err_any;
         if (is_lmr && !any_open && lmr_legal) begin
            cl_q <= sdram_a[6:4];
            bl_q <= sdram_a[2:0];
         end
         if (is_act && !tgt_open) begin
            bank_open[sdram_ba] <= 1'b1;
            row_q[sdram_ba]     <= sdram_a[ROW_BITS-1:0];
         end
         if (is_pre) begin
            if (sdram_a[10]) bank_open <= '0;
            else             bank_open[sdram_ba] <= 1'b0;
         end
         if (rw_go) begin
            state  <= (!page && bl_left == 3'd0) ? B_IDLE : (is_wr ? B_WRITE : B_READ);
            b_bank <= sdram_ba;
            b_col  <= col_next(sdram_a[COL_BITS-1:0], bl_q);
            b_left <= bl_left;
         end else if (state != B_IDLE && stop) begin
            state <= B_IDLE;
         end else if (cont) begin
            b_col  <= col_next(b_col, bl_q);
            b_left <= b_left - 3'd1;
            if (!page && b_left == 3'd1) state <= B_IDLE;
         end
      end
   end

   // Backing RAM: single port, write-through on write accesses, registered read
   always_ff @(posedge clk) begin
      if (acc_en && acc_wr) mem[acc_addr] <= sdram_dq_in;
      rd_q <= mem[acc_addr];
   end

   // Read data path: RAM register then CL-1 delay stages; an accepted WRITE empties it at once
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_vld       <= 1'b0;
         p1_vld       <= 1'b0;
         p2_vld       <= 1'b0;
         p1_dat       <= '0;
         p2_dat       <= '0;
         sdram_dq_oe  <= 1'b0;
         sdram_dq_out <= '0;
      end else if (rw_go && is_wr) begin
         rd_vld       <= 1'b0;
         p1_vld       <= 1'b0;
         p2_vld       <= 1'b0;
         sdram_dq_oe  <= 1'b0;
         sdram_dq_out <= '0;
      end else begin
         rd_vld       <= acc_en & ~acc_wr;
         sdram_dq_oe  <= p1_vld;
         sdram_dq_out <= p1_vld ? p1_dat : '0;
         p1_vld       <= p2_vld;
         p1_dat       <= p2_dat;
         p2_vld       <= 1'b0;
         if (rd_vld) begin
            if (cl_q == 3'd2) begin
               p1_vld <= 1'b1;
               p1_dat <= rd_q;
            end else begin
               p2_vld <= 1'b1;
               p2_dat <= rd_q;
            end
         end
      end
   end
endmodule
